led_blink_sequencer: RTL and testbench
======================================

# led_blink_sequencer

Command-driven sequencer for the board LED. It accepts a blink job on a single-cycle start handshake: blink count, on-time and off-time, with durations counted in prescaled ticks. It then plays the job on `led_out` and reports completion with a one-cycle `done_out` pulse. It owns the LED output and sits between the top-level control logic (buttons or a host register) and the pin.

## Interface
Parameters:
- `TICK_DIV`, 100_000: clock cycles per duration tick; must be ≥2. Use 4 in simulation.
- `DUR_W`, 8: width of the on/off duration fields, in ticks.
- `CNT_W`, 4: width of the blink-count field.

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: reset, synchronous and active-high.
- `start_in` in 1: request to accept a job; honoured only in IDLE.
- `on_ticks_in` in DUR_W: LED-on duration per blink; sampled on accept.
- `off_ticks_in` in DUR_W: LED-off duration per blink; sampled on accept.
- `count_in` in CNT_W: number of blinks; sampled on accept.
- `abort_in` in 1: cancel the running job.
- `led_out` out 1: LED drive.
- `busy_out` out 1: high from the cycle after accept through the DONE cycle.
- `done_out` out 1: one-cycle pulse at normal completion.
- `blinks_left_out` out CNT_W: blinks not yet started or finished.

## Operation
- States: IDLE, ON, OFF, DONE.
- IDLE outputs: led=0, busy=0, done=0.
- Accept condition: `start_in` high in IDLE with `abort_in` low. On accept:
  - latch durations; a zero duration is latched as 1;
  - latch count into `blinks_left_out`;
  - clear the prescaler.
- Accept transitions:
  - count==0: go IDLE→DONE, with no LED activity.
  - otherwise: go IDLE→ON.
- Prescaler:
  - counts 0..TICK_DIV-1 while in ON or OFF and wraps;
  - `tick` fires on the wrap cycle;
  - is not reset at ON↔OFF changes.
- Duration counter:
  - loaded with the latched on/off value on entry to ON/OFF;
  - at each tick: if it equals 1, change phase; otherwise decrement.
- ON (led=1), phase end → OFF: reload with off-time and decrement `blinks_left_out`.
- OFF (led=0), phase end:
  - `blinks_left_out`==0: go to DONE;
  - otherwise: go to ON and reload with on-time.
- Every blink, including the last, has its full off period.
- DONE: led=0, busy=1, done=1 for exactly one cycle, then IDLE.
- `start_in` outside IDLE is ignored, not queued.
- `abort_in` in ON, OFF or DONE:
  - next state is IDLE;
  - led=0, busy=0, `blinks_left_out`=0;
  - no `done_out` pulse;
  - abort in DONE suppresses nothing already emitted.
- `abort_in` in IDLE does nothing except block a same-cycle start; abort wins.
- Inputs are not registered further; sampling happens on the accept edge only.

## Timing
- Reset values: led=0, busy=0, done=0, `blinks_left_out`=0, state IDLE, prescaler 0.
- Reset mid-job takes effect on the next edge and overrides everything.
- D = TICK_DIV. With accept on edge k:
  - busy and led high from cycle k+1;
  - ON lasts exactly on×D cycles, OFF exactly off×D cycles.
- Job with n≥1 blinks:
  - `done_out` high at cycle k+1+n·(on+off)·D;
  - busy falls the following cycle.
- count==0: `done_out` at k+1, busy high only in that cycle.
- Earliest next accept is the first IDLE cycle after DONE, i.e. the cycle busy is low.
- `blinks_left_out` updates on the same edge where led falls.

## Test plan
- TICK_DIV=4, on=2, off=1, count=3, start at k:
  - led high k+1..k+8, low k+9..k+12, repeating;
  - `done_out` only at k+37;
  - busy low at k+38;
  - `blinks_left_out` steps 3→2→1→0 at k+9, k+21, k+33.
- count=0: `done_out` at k+1, led never high, busy high only at k+1.
- on=0, off=0, count=1, TICK_DIV=4: treated as 1/1; led high 4 cycles, low 4, done at k+9.
- Abort at k+5 of the first scenario: at k+6 led=0, busy=0, `blinks_left_out`=0; no `done_out`. A start at k+6 is accepted.
- Start pulsed at k+3 while busy is ignored; the job matches the first scenario exactly. Start and abort together in IDLE: no accept.
- rst_in asserted at k+10 mid-job: all outputs at reset values next cycle; a start afterwards runs normally.

Source files
------------

// File: rtl/led_blink_sequencer.sv
// Command-driven LED blink sequencer: accepts a {count, on, off} job on a start
// handshake, plays it on led_out in prescaled ticks, and pulses done_out at the end.
module led_blink_sequencer #(
  parameter int unsigned TICK_DIV = 100_000,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [DUR_W-1:0] on_ticks_in,
  input  logic [DUR_W-1:0] off_ticks_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic             abort_in,
  output logic             led_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [CNT_W-1:0] blinks_left_out
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] on_q, on_d;
  logic [DUR_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] blinks_q, blinks_d;
  logic             running;
  logic             tick;
  logic [DUR_W-1:0] on_fix;
  logic [DUR_W-1:0] off_fix;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      dur_q    <= '0;
      on_q     <= '0;
      off_q    <= '0;
      blinks_q <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      dur_q    <= dur_d;
      on_q     <= on_d;
      off_q    <= off_d;
      blinks_q <= blinks_d;
    end
  end

  // Zero-length phases would never see their tick; they are stretched to one tick.
  assign on_fix  = (on_ticks_in  == '0) ? DUR_ONE : on_ticks_in;
  assign off_fix = (off_ticks_in == '0) ? DUR_ONE : off_ticks_in;

  assign running = (state_q == S_ON) || (state_q == S_OFF);
  assign tick    = running && (presc_q == PRESC_MAX);

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    on_d     = on_q;
    off_d    = off_q;
    blinks_d = blinks_q;
    presc_d  = '0;
    if (running) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_in && !abort_in) begin
          on_d     = on_fix;
          off_d    = off_fix;
          dur_d    = on_fix;
          blinks_d = count_in;
          presc_d  = '0;
          state_d  = (count_in == '0) ? S_DONE : S_ON;
        end
      end
      S_ON: begin
        if (abort_in) begin
          state_d  = S_IDLE;
          blinks_d = '0;
          presc_d  = '0;
        end else if (tick) begin
          if (dur_q == DUR_ONE) begin
            state_d  = S_OFF;
            dur_d    = off_q;
            blinks_d = blinks_q - 1'b1;
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      S_OFF: begin
        if (abort_in) begin
          state_d  = S_IDLE;
          blinks_d = '0;
          presc_d  = '0;
        end else if (tick) begin
          if (dur_q == DUR_ONE) begin
            if (blinks_q == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ON;
              dur_d   = on_q;
            end
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort_in) begin
          blinks_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        blinks_d = '0;
      end
    endcase
  end

  assign led_out         = (state_q == S_ON);
  assign busy_out        = (state_q != S_IDLE);
  assign done_out        = (state_q == S_DONE);
  assign blinks_left_out = blinks_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer: directed job table plus random jobs, each checked
// cycle by cycle against an arithmetic model of the blink timeline.
module tb_led_blink_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] on_ticks;
  logic [7:0] off_ticks;
  logic [3:0] count;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;
  logic [3:0] blinks;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int on;
    int off;
    int cnt;
    int abort_at;
    int rst_at;
    int spur_at;
    int len;
    int exp_done;
  } vec_t;

  led_blink_sequencer #(
    .TICK_DIV(D),
    .DUR_W   (8),
    .CNT_W   (4)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .start_in       (start),
    .on_ticks_in    (on_ticks),
    .off_ticks_in   (off_ticks),
    .count_in       (count),
    .abort_in       (abort),
    .led_out        (led),
    .busy_out       (busy),
    .done_out       (done),
    .blinks_left_out(blinks)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int t, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // Expected outputs t cycles after accept; everything idles after cycle 'cut'.
  function automatic void model(input int on, input int off, input int cnt, input int t,
                                input int cut, output int e_led, output int e_busy,
                                output int e_done, output int e_bl);
    int a, b, p, fin;
    e_led = 0; e_busy = 0; e_done = 0; e_bl = 0;
    if (t > cut) return;
    a   = (on == 0) ? 1 : on;
    b   = (off == 0) ? 1 : off;
    p   = (a + b) * D;
    fin = cnt * p;
    if (t >= 1 && t <= fin) begin
      e_busy = 1;
      e_led  = (((t - 1) % p) < a * D) ? 1 : 0;
      e_bl   = cnt - ((t - 1 + b * D) / p);
    end else if (t == fin + 1) begin
      e_busy = 1;
      e_done = 1;
    end
  endfunction

  task automatic check_idle(input string tag, input int t);
    check({tag, "_led"}, t, int'(led), 0);
    check({tag, "_busy"}, t, int'(busy), 0);
    check({tag, "_done"}, t, int'(done), 0);
    check({tag, "_blinks"}, t, int'(blinks), 0);
  endtask

  task automatic run_job(input vec_t v);
    int seen_done;
    int cut;
    int e_led, e_busy, e_done, e_bl;
    seen_done = 0;
    cut = 1000000;
    if (v.abort_at > 0) cut = v.abort_at;
    if (v.rst_at > 0 && v.rst_at < cut) cut = v.rst_at;
    abort = 1'b0; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle("pre", 0);
    on_ticks  = 8'(v.on);
    off_ticks = 8'(v.off);
    count     = 4'(v.cnt);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= v.len; t++) begin
      on_ticks  = 8'($urandom);
      off_ticks = 8'($urandom);
      count     = 4'($urandom);
      abort     = (t == v.abort_at);
      rst       = (t == v.rst_at);
      start     = (t == v.spur_at);
      @(negedge clk);
      model(v.on, v.off, v.cnt, t, cut, e_led, e_busy, e_done, e_bl);
      check("led", t, int'(led), e_led);
      check("busy", t, int'(busy), e_busy);
      check("done", t, int'(done), e_done);
      check("blinks", t, int'(blinks), e_bl);
      if (done && seen_done == 0) seen_done = t;
      @(posedge clk); #1;
    end
    abort = 1'b0; rst = 1'b0; start = 1'b0;
    check("done_time", v.len, seen_done, v.exp_done);
  endtask

  vec_t tbl[9];

  initial begin
    // on, off, cnt, abort_at, rst_at, spur_at, len, exp_done
    tbl[0] = '{2, 1, 3, 0, 0, 0, 40, 37};
    tbl[1] = '{5, 5, 0, 0, 0, 0, 3, 1};
    tbl[2] = '{0, 0, 1, 0, 0, 0, 11, 9};
    tbl[3] = '{2, 1, 3, 5, 0, 0, 5, 0};
    tbl[4] = '{1, 2, 2, 0, 0, 0, 27, 25};
    tbl[5] = '{2, 1, 3, 0, 0, 3, 40, 37};
    tbl[6] = '{2, 1, 3, 0, 10, 0, 12, 0};
    tbl[7] = '{1, 1, 1, 0, 0, 0, 11, 9};
    tbl[8] = '{1, 1, 1, 9, 0, 0, 11, 9};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    on_ticks = '0; off_ticks = '0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset", 0);

    foreach (tbl[i]) run_job(tbl[i]);

    // Start and abort together while idle: abort wins, nothing is accepted.
    @(negedge clk);
    on_ticks = 8'd1; off_ticks = 8'd1; count = 4'd2;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      check("sa_busy", t, int'(busy), 0);
      check("sa_led", t, int'(led), 0);
    end

    for (int n = 0; n < 20; n++) begin
      vec_t v;
      int a, b, fin, cut;
      v.on  = $urandom_range(0, 3);
      v.off = $urandom_range(0, 3);
      v.cnt = $urandom_range(0, 3);
      a = (v.on == 0) ? 1 : v.on;
      b = (v.off == 0) ? 1 : v.off;
      fin = v.cnt * (a + b) * D + 1;
      v.len = fin + 2;
      v.rst_at = 0;
      v.abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, fin + 1) : 0;
      v.spur_at = $urandom_range(1, fin);
      if (v.abort_at > 0 && v.spur_at >= v.abort_at) v.spur_at = 0;
      cut = (v.abort_at > 0) ? v.abort_at : 1000000;
      v.exp_done = (cut >= fin) ? fin : 0;
      run_job(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
